// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for receiver and transmitter
//   uart_state_t    : frame FSM states
//   FRAME_DATA_BITS : data bits per frame
//   clks_per_bit()  : clock cycles per bit time
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int FRAME_DATA_BITS = 8;
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
//   clk, reset : clock, async active-high reset (both flops load RESET_VAL)
//   d          : asynchronous input
//   q          : synchronized output
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge reset)
        if (reset) {q, meta} <= {RESET_VAL, RESET_VAL};
        else       {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, false-start rejection and framing-error flag
//   clk, reset : clock, async active-high reset
//   rx_line    : serial input, idle high, asynchronous
//   data       : last good byte, updated with rx_valid
//   rx_valid   : one-cycle pulse on a frame with a good stop bit
//   rx_busy    : high while a frame is in progress
//   frame_err  : one-cycle pulse when the stop bit samples low
module uart_rx import uart_pkg::*; #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_line,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);
    localparam int          CPB      = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [15:0] CPB_M1   = 16'(CPB - 1);
    localparam logic [15:0] HALF_M1  = 16'(CPB / 2 - 1);
    localparam logic [2:0]  LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    logic        rx_s;
    uart_state_t state, state_n;
    logic [15:0] clk_count, clk_count_n;
    logic [2:0]  bit_index, bit_index_n;
    logic [7:0]  shift, shift_n, data_n;
    logic        rx_valid_n, frame_err_n;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(rx_line), .q(rx_s));

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            clk_count <= '0;
            bit_index <= '0;
            shift     <= '0;
            data      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            clk_count <= clk_count_n;
            bit_index <= bit_index_n;
            shift     <= shift_n;
            data      <= data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
        end

    // Returning to IDLE at mid-stop-bit lets a back-to-back start bit be caught without a gap.
    always_comb begin
        state_n     = state;
        clk_count_n = clk_count;
        bit_index_n = bit_index;
        shift_n     = shift;
        data_n      = data;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE:
                if (!rx_s) begin
                    state_n     = START;
                    clk_count_n = '0;
                end
            START: begin
                clk_count_n = clk_count + 16'd1;
                if (clk_count == HALF_M1) begin
                    state_n     = rx_s ? IDLE : DATA;
                    clk_count_n = '0;
                    bit_index_n = '0;
                end
            end
            DATA: begin
                clk_count_n = clk_count + 16'd1;
                if (clk_count == CPB_M1) begin
                    shift_n[bit_index] = rx_s;
                    clk_count_n        = '0;
                    bit_index_n        = bit_index + 3'd1;
                    state_n            = (bit_index == LAST_BIT) ? STOP : DATA;
                end
            end
            STOP: begin
                clk_count_n = clk_count + 16'd1;
                if (clk_count == CPB_M1) begin
                    data_n      = rx_s ? shift : data;
                    rx_valid_n  = rx_s;
                    frame_err_n = !rx_s;
                    clk_count_n = '0;
                    state_n     = IDLE;
                end
            end
        endcase
    end

    assign rx_busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CPB=16, HALF=8
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int STOP_EDGE = 2 + CPB / 2 + 9 * CPB;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_line = 1'b1;
    logic [7:0] data;
    logic       rx_valid, rx_busy, frame_err;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         e0 = 0;
    int         rise_cyc = -1;
    int         fall_cyc = -1;
    logic       busy_q = 1'b0;
    logic [7:0] last_good = 8'h00;
    sb_t        sb[$];
    sb_t        e_mon;

    uart_rx #(.CLK_FREQ(160), .BAUD_RATE(10)) dut (
        .clk(clk), .reset(reset), .rx_line(rx_line),
        .data(data), .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves the line idle-high at a negedge after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        sb_t e;
        rx_line = 1'b0;
        e0 = cyc + 1;
        e.err  = !stop;
        e.data = stop ? b : last_good;
        e.cyc  = e0 + STOP_EDGE;
        if (stop) last_good = b;
        sb.push_back(e);
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_line = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx_line = stop;
        repeat (CPB) @(negedge clk);
        rx_line = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_busy && !busy_q) rise_cyc = cyc;
            if (!rx_busy && busy_q) fall_cyc = cyc;
            if (rx_valid || frame_err) begin
                check("excl", {31'd0, rx_valid & frame_err}, 0);
                if (sb.size() == 0) check("unexpected_pulse", {30'd0, rx_valid, frame_err}, 0);
                else begin
                    e_mon = sb.pop_front();
                    check("kind", {31'd0, frame_err}, {31'd0, e_mon.err});
                    check("pulse_cycle", cyc, e_mon.cyc);
                    check("data", {24'd0, data}, {24'd0, e_mon.data});
                end
            end
        end
        busy_q = rx_busy;
    end

    initial begin
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data}, 0);
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_ferr", {31'd0, frame_err}, 0);
        check("rst_busy", {31'd0, rx_busy}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("single_busy_rise", rise_cyc - e0, 2);
        check("single_busy_fall", fall_cyc - e0, STOP_EDGE);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (10) @(negedge clk);

        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);

        rx_line = 1'b0;
        e0 = cyc + 1;
        repeat (4) @(negedge clk);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_rise", rise_cyc - e0, 2);
        check("glitch_busy_fall", fall_cyc - e0, 2 + CPB / 2);
        send_frame(8'h5A, 1'b1);
        repeat (10) @(negedge clk);

        b = 8'h81;
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rx_line = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx_line = b[3];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_data", {24'd0, data}, 0);
        check("midrst_valid", {31'd0, rx_valid}, 0);
        check("midrst_ferr", {31'd0, frame_err}, 0);
        check("midrst_busy", {31'd0, rx_busy}, 0);
        last_good = 8'h00;
        @(negedge clk);
        rx_line = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h42, 1'b1);

        for (int i = 0; i < 256; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);

        repeat (200) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the serial link: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous `rx_line` and presents each byte on a parallel port with a one-cycle valid strobe. It sits between the board RX pin and the CPU's I/O register file and is the receiving counterpart of the existing transmitter, using the same clock and baud parameters. It includes a metastability synchronizer, mid-bit sampling, false-start rejection and framing-error detection.

## Interface
- `CLK_FREQ`, default 50000000, system clock frequency in Hz.
- `BAUD_RATE`, default 9600, line rate in bit/s.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `rx_line`  in  1  serial input, idle high, asynchronous to `clk`.
- `data`  out  8  last good byte; updated only with `rx_valid`.
- `rx_valid`  out  1  one-cycle pulse when a frame with a valid stop bit completes.
- `rx_busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.

## Operation
- Derived constants:
  - `CPB = CLK_FREQ/BAUD_RATE`, integer division.
  - `HALF = CPB/2`.
  - `CPB` must lie in 4..65535. The 16-bit `clk_count` covers this range.
- Synchronizer: two flops, both reset to 1. All logic uses only the second-flop output `rx_s`.
- FSM states are IDLE, START, DATA, STOP:
  - **IDLE:** when `rx_s==0`, go to START with `clk_count=0`.
  - **START:** increment `clk_count`. At the edge where `clk_count==HALF-1`:
    - if `rx_s==0`, go to DATA with `clk_count=0`, `bit_index=0`;
    - otherwise the frame is a false start: go to IDLE with no output pulse.
  - **DATA:** increment `clk_count`. At the edge where `clk_count==CPB-1`:
    - set `shift[bit_index] = rx_s` and `clk_count=0`;
    - if `bit_index==7`, go to STOP; otherwise `bit_index+1`.
  - **STOP:** increment `clk_count`. At the edge where `clk_count==CPB-1`:
    - if `rx_s==1`, `data <= shift` and pulse `rx_valid`;
    - otherwise pulse `frame_err` and leave `data` unchanged;
    - in both cases go to IDLE.
- IDLE is re-entered at mid-stop-bit, so a back-to-back start bit is detected with no gap needed.
- There is no receive buffer. A consumer that misses the `rx_valid` pulse loses the byte; `data` holds until the next good frame.
- `rx_valid` and `frame_err` are never high together.

## Timing
- Reset values: `data=8'h00`, `rx_valid=0`, `frame_err=0`, `rx_busy=0`, state IDLE, `clk_count=0`, `bit_index=0`, `shift=0`, sync flops=1.
- Reset asserted mid-frame aborts the frame immediately: no pulse, `data` is cleared. Reset dominates all other events.
- Edge numbering: E0 is the first `clk` edge after `rx_line` falls.
  - `rx_s` goes low after E1; START is entered at E2.
  - The start-bit check is at E(2+HALF).
  - Data bit k is sampled at E(2+HALF+(k+1)·CPB).
  - The stop decision is at E(2+HALF+9·CPB). `rx_valid`/`frame_err` are high for exactly the cycle after that edge.
- `rx_busy` rises at E2 and falls at the stop-decision edge.
- A low pulse on `rx_line` shorter than about HALF−2 cycles is rejected as a false start. `rx_busy` is high only during the START dwell.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/STOP);
  - a `clks_per_bit(clk_freq, baud)` function;
  - a `FRAME_DATA_BITS=8` constant. The transmitter reuses this package.
- Sub-module `sync_2ff`: a generic 2-flop synchronizer with a reset-value parameter, instantiated with reset value 1. It is also reusable for other asynchronous inputs.
- The FSM, counters and shift register live in `uart_rx` itself.

## Test plan
Test parameters: `CLK_FREQ=160`, `BAUD_RATE=10`, giving `CPB=16` and `HALF=8`.

- **Single byte:** drive 0xA5 as 8N1 starting at E0. Expect `rx_valid` high only in the cycle after E154, `data==8'hA5`, `frame_err` never high, `rx_busy` high from E2 to E154.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap. Expect two `rx_valid` pulses 160 cycles apart, with `data` 0x00 then 0xFF.
- **Framing error:** send 0x3C with the stop bit driven low. Expect a `frame_err` pulse at the stop edge, no `rx_valid`, and `data` still holding the previous byte.
- **Glitch:** drive `rx_line` low for 4 cycles, then high. Expect no `rx_valid` or `frame_err`, `rx_busy` falling by E10, and a following 0x5A received correctly.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0x81. Expect all outputs at their reset values immediately, no pulse, and the next frame 0x42 received correctly.
- **Loopback:** connect the transmitter output to `rx_line` and send 256 random bytes. Every byte must match and no `frame_err` may occur.
